// File: rtl/common_pkg.sv
// Shared types and bus widths for the slot-arbitrated Wishbone fabric.
package common_pkg;

    localparam int WB_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH    = 8;

    // Slot owner of the time-division frame (slot indices 0 and 1 both map to the CPU)
    typedef enum logic [1:0] {
        SLOT_CPU   = 2'd0,
        SLOT_VIDEO = 2'd2,
        SLOT_SPI   = 2'd3
    } slot_e;

    // Which controller currently owns an accepted bus cycle
    typedef enum logic [1:0] {
        OWN_IDLE       = 2'd0,
        OWN_SPI_BUSY   = 2'd1,
        OWN_VIDEO_BUSY = 2'd2
    } owner_e;

    // Map the two slot-index bits of the frame counter onto the slot owner
    function automatic slot_e slot_decode(input logic [1:0] slot_idx);
        slot_e slot_v;
        case (slot_idx)
            2'd0:    slot_v = SLOT_CPU;
            2'd1:    slot_v = SLOT_CPU;
            2'd2:    slot_v = SLOT_VIDEO;
            2'd3:    slot_v = SLOT_SPI;
            default: slot_v = SLOT_CPU;
        endcase
        return slot_v;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Free-running frame counter: four slots of SLOT_CYCLES cycles each.
// Reports the current slot, a strobe on the first cycle of every slot and
// a flag on the last cycle of every slot.
module slot_timer
    import common_pkg::*;
#(
    parameter int SLOT_CYCLES = 16
) (
    input  logic  clk_i,
    input  logic  rst_i,
    output slot_e slot_o,
    output logic  strobe_o,
    output logic  last_o
);

    localparam int CW = $clog2(4 * SLOT_CYCLES);
    localparam int LW = $clog2(SLOT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter wraps naturally because the frame length is a power of two
    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    // Counter register with synchronous reset to the start of a CPU slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Slot decode from the top two bits, boundary flags from the low bits
    always_comb begin
        slot_o   = slot_decode(cnt_q[CW-1:LW]);
        strobe_o = (cnt_q[LW-1:0] == '0);
        last_o   = (&cnt_q[LW-1:0]);
    end

endmodule

// File: rtl/wb_slot_arbiter.sv
// Time-slot arbiter sharing one Wishbone bus between a video and an SPI
// controller, with two CPU slots per frame that never drive the bus.
// A controller may start one cycle at the first cycle of its slot; the
// cycle ends on ack, on the controller dropping cycle_i, or is aborted
// with err/timeout on the last cycle of the slot.
module wb_slot_arbiter
    import common_pkg::*;
#(
    parameter int SLOT_CYCLES = 16
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic [WB_ADDR_WIDTH-1:0] spi_addr_i,
    input  logic [DATA_WIDTH-1:0]    spi_data_i,
    input  logic                     spi_we_i,
    input  logic                     spi_cycle_i,
    input  logic                     spi_strobe_i,
    output logic [DATA_WIDTH-1:0]    spi_data_o,
    output logic                     spi_stall_o,
    output logic                     spi_ack_o,
    output logic                     spi_err_o,
    input  logic [WB_ADDR_WIDTH-1:0] video_addr_i,
    input  logic [DATA_WIDTH-1:0]    video_data_i,
    input  logic                     video_we_i,
    input  logic                     video_cycle_i,
    input  logic                     video_strobe_i,
    output logic [DATA_WIDTH-1:0]    video_data_o,
    output logic                     video_stall_o,
    output logic                     video_ack_o,
    output logic                     video_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    output logic                     cpu_grant_o,
    output logic                     grant_strobe_o,
    output logic                     timeout_o
);

    slot_e  slot_s;
    logic   slot_strobe_s;
    logic   slot_last_s;
    owner_e owner_q;
    owner_e owner_d;
    logic   accept_video_s;
    logic   accept_spi_s;

    slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_slot_timer (
        .clk_i   (wb_clock_i),
        .rst_i   (wb_reset_i),
        .slot_o  (slot_s),
        .strobe_o(slot_strobe_s),
        .last_o  (slot_last_s)
    );

    // Read data goes straight back to both controllers; only ack qualifies it
    assign spi_data_o   = wb_data_i;
    assign video_data_o = wb_data_i;

    // Slot status, silenced while reset is held
    always_comb begin
        cpu_grant_o    = (!wb_reset_i) && (slot_s == SLOT_CPU);
        grant_strobe_o = (!wb_reset_i) && slot_strobe_s;
    end

    // A request is taken only at the opening cycle of its own slot with the bus free
    always_comb begin
        accept_video_s = 1'b0;
        accept_spi_s   = 1'b0;
        if ((!wb_reset_i) && (owner_q == OWN_IDLE) && slot_strobe_s && (!wb_stall_i)) begin
            accept_video_s = (slot_s == SLOT_VIDEO) && video_cycle_i && video_strobe_i;
            accept_spi_s   = (slot_s == SLOT_SPI) && spi_cycle_i && spi_strobe_i;
        end else begin
            accept_video_s = 1'b0;
            accept_spi_s   = 1'b0;
        end
    end

    // Owner FSM next state and per-controller handshake responses
    always_comb begin
        owner_d       = owner_q;
        wb_strobe_o   = accept_video_s || accept_spi_s;
        video_stall_o = !accept_video_s;
        spi_stall_o   = !accept_spi_s;
        video_ack_o   = 1'b0;
        video_err_o   = 1'b0;
        spi_ack_o     = 1'b0;
        spi_err_o     = 1'b0;
        timeout_o     = 1'b0;
        if (wb_reset_i) begin
            owner_d = OWN_IDLE;
        end else begin
            case (owner_q)
                OWN_IDLE: begin
                    if (accept_video_s) begin
                        owner_d = OWN_VIDEO_BUSY;
                    end else if (accept_spi_s) begin
                        owner_d = OWN_SPI_BUSY;
                    end else begin
                        owner_d = OWN_IDLE;
                    end
                end
                OWN_VIDEO_BUSY: begin
                    if (!video_cycle_i) begin
                        owner_d = OWN_IDLE;
                    end else if (wb_ack_i) begin
                        video_ack_o = 1'b1;
                        owner_d     = OWN_IDLE;
                    end else if (slot_last_s) begin
                        video_err_o = 1'b1;
                        timeout_o   = 1'b1;
                        owner_d     = OWN_IDLE;
                    end else begin
                        owner_d = OWN_VIDEO_BUSY;
                    end
                end
                OWN_SPI_BUSY: begin
                    if (!spi_cycle_i) begin
                        owner_d = OWN_IDLE;
                    end else if (wb_ack_i) begin
                        spi_ack_o = 1'b1;
                        owner_d   = OWN_IDLE;
                    end else if (slot_last_s) begin
                        spi_err_o = 1'b1;
                        timeout_o = 1'b1;
                        owner_d   = OWN_IDLE;
                    end else begin
                        owner_d = OWN_SPI_BUSY;
                    end
                end
                default: begin
                    owner_d = OWN_IDLE;
                end
            endcase
        end
    end

    // Owner register; reset drops any cycle in flight without a response
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Bus request mux: the owner while busy, otherwise the current slot's controller
    always_comb begin
        wb_addr_o  = '0;
        wb_data_o  = '0;
        wb_we_o    = 1'b0;
        wb_cycle_o = 1'b0;
        if (wb_reset_i) begin
            wb_we_o    = 1'b0;
            wb_cycle_o = 1'b0;
        end else if ((owner_q == OWN_VIDEO_BUSY) ||
                     ((owner_q == OWN_IDLE) && (slot_s == SLOT_VIDEO))) begin
            wb_addr_o  = video_addr_i;
            wb_data_o  = video_data_i;
            wb_we_o    = video_we_i;
            wb_cycle_o = video_cycle_i;
        end else if ((owner_q == OWN_SPI_BUSY) ||
                     ((owner_q == OWN_IDLE) && (slot_s == SLOT_SPI))) begin
            wb_addr_o  = spi_addr_i;
            wb_data_o  = spi_data_i;
            wb_we_o    = spi_we_i;
            wb_cycle_o = spi_cycle_i;
        end else begin
            wb_we_o    = 1'b0;
            wb_cycle_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_slot_arbiter.sv
// Self-checking bench for wb_slot_arbiter: directed scenarios, a frame-level
// reference model compared every cycle, and hand-computed spot checks.
module tb_wb_slot_arbiter;
    import common_pkg::*;

    localparam int SC    = 16;
    localparam int FRAME = 4 * SC;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [WB_ADDR_WIDTH-1:0] spi_addr_i = '0;
    logic [DATA_WIDTH-1:0]    spi_data_i = '0;
    logic                     spi_we_i = 1'b0, spi_cycle_i = 1'b0, spi_strobe_i = 1'b0;
    logic [DATA_WIDTH-1:0]    spi_data_o;
    logic                     spi_stall_o, spi_ack_o, spi_err_o;
    logic [WB_ADDR_WIDTH-1:0] video_addr_i = '0;
    logic [DATA_WIDTH-1:0]    video_data_i = '0;
    logic                     video_we_i = 1'b0, video_cycle_i = 1'b0, video_strobe_i = 1'b0;
    logic [DATA_WIDTH-1:0]    video_data_o;
    logic                     video_stall_o, video_ack_o, video_err_o;
    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [DATA_WIDTH-1:0]    wb_data_o;
    logic                     wb_we_o, wb_cycle_o, wb_strobe_o;
    logic [DATA_WIDTH-1:0]    wb_data_i = '0;
    logic                     wb_stall_i = 1'b0, wb_ack_i = 1'b0;
    logic                     cpu_grant_o, grant_strobe_o, timeout_o;

    int checks = 0;
    int failures = 0;
    int strobes_seen = 0;

    always #5 clk = ~clk;

    wb_slot_arbiter #(.SLOT_CYCLES(SC)) dut (
        .wb_clock_i(clk), .wb_reset_i(rst),
        .spi_addr_i(spi_addr_i), .spi_data_i(spi_data_i), .spi_we_i(spi_we_i),
        .spi_cycle_i(spi_cycle_i), .spi_strobe_i(spi_strobe_i),
        .spi_data_o(spi_data_o), .spi_stall_o(spi_stall_o), .spi_ack_o(spi_ack_o), .spi_err_o(spi_err_o),
        .video_addr_i(video_addr_i), .video_data_i(video_data_i), .video_we_i(video_we_i),
        .video_cycle_i(video_cycle_i), .video_strobe_i(video_strobe_i),
        .video_data_o(video_data_o), .video_stall_o(video_stall_o), .video_ack_o(video_ack_o),
        .video_err_o(video_err_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_cycle_o(wb_cycle_o),
        .wb_strobe_o(wb_strobe_o), .wb_data_i(wb_data_i), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
        .cpu_grant_o(cpu_grant_o), .grant_strobe_o(grant_strobe_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_cyc: cycles since reset release; m_owner: 0 none, 1 video, 2 spi
    int m_cyc = 0, n_cyc = 0;
    int m_owner = 0, n_owner = 0;
    bit m_valid = 1'b0, n_valid = 1'b0;

    always @(negedge clk) begin
        int ph, sl, src;
        bit first, last, acc_v, acc_s;
        bit e_vack, e_verr, e_sack, e_serr, e_to;
        n_valid = m_valid || rst;
        if (rst) begin
            n_cyc   = 0;
            n_owner = 0;
            if (m_valid) begin
                chk("rst_spi_stall", spi_stall_o, 1);
                chk("rst_video_stall", video_stall_o, 1);
                chk("rst_spi_ack", spi_ack_o, 0);
                chk("rst_video_ack", video_ack_o, 0);
                chk("rst_spi_err", spi_err_o, 0);
                chk("rst_video_err", video_err_o, 0);
                chk("rst_timeout", timeout_o, 0);
                chk("rst_wb_strobe", wb_strobe_o, 0);
                chk("rst_wb_cycle", wb_cycle_o, 0);
                chk("rst_cpu_grant", cpu_grant_o, 0);
            end
        end else begin
            ph    = m_cyc % FRAME;
            sl    = ph / SC;
            first = (ph % SC) == 0;
            last  = (ph % SC) == SC - 1;
            acc_v = (m_owner == 0) && first && (sl == 2) && video_strobe_i && video_cycle_i && !wb_stall_i;
            acc_s = (m_owner == 0) && first && (sl == 3) && spi_strobe_i && spi_cycle_i && !wb_stall_i;
            e_vack = 0; e_verr = 0; e_sack = 0; e_serr = 0; e_to = 0;
            n_owner = m_owner;
            if (acc_v) n_owner = 1;
            if (acc_s) n_owner = 2;
            if (m_owner == 1) begin
                if (!video_cycle_i) n_owner = 0;
                else if (wb_ack_i) begin e_vack = 1; n_owner = 0; end
                else if (last) begin e_verr = 1; e_to = 1; n_owner = 0; end
            end
            if (m_owner == 2) begin
                if (!spi_cycle_i) n_owner = 0;
                else if (wb_ack_i) begin e_sack = 1; n_owner = 0; end
                else if (last) begin e_serr = 1; e_to = 1; n_owner = 0; end
            end
            src = (m_owner != 0) ? m_owner : ((sl == 2) ? 1 : ((sl == 3) ? 2 : 0));
            if (m_valid) begin
                chk("m_cpu_grant", cpu_grant_o, (sl < 2));
                chk("m_grant_strobe", grant_strobe_o, first);
                chk("m_wb_strobe", wb_strobe_o, acc_v || acc_s);
                chk("m_video_stall", video_stall_o, !acc_v);
                chk("m_spi_stall", spi_stall_o, !acc_s);
                chk("m_video_ack", video_ack_o, e_vack);
                chk("m_video_err", video_err_o, e_verr);
                chk("m_spi_ack", spi_ack_o, e_sack);
                chk("m_spi_err", spi_err_o, e_serr);
                chk("m_timeout", timeout_o, e_to);
                chk("m_spi_data", spi_data_o, wb_data_i);
                chk("m_video_data", video_data_o, wb_data_i);
                if (src == 1) begin
                    chk("m_wb_cycle", wb_cycle_o, video_cycle_i);
                    chk("m_wb_we", wb_we_o, video_we_i);
                    chk("m_wb_addr", wb_addr_o, video_addr_i);
                    chk("m_wb_data", wb_data_o, video_data_i);
                end else if (src == 2) begin
                    chk("m_wb_cycle", wb_cycle_o, spi_cycle_i);
                    chk("m_wb_we", wb_we_o, spi_we_i);
                    chk("m_wb_addr", wb_addr_o, spi_addr_i);
                    chk("m_wb_data", wb_data_o, spi_data_i);
                end else begin
                    chk("m_wb_cycle", wb_cycle_o, 0);
                    chk("m_wb_we", wb_we_o, 0);
                end
            end
            n_cyc = m_cyc + 1;
        end
    end

    always @(posedge clk) begin
        m_cyc   <= n_cyc;
        m_owner <= n_owner;
        m_valid <= n_valid;
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        spi_addr_i = '0; spi_data_i = '0; spi_we_i = 1'b0; spi_cycle_i = 1'b0; spi_strobe_i = 1'b0;
        video_addr_i = '0; video_data_i = '0; video_we_i = 1'b0; video_cycle_i = 1'b0; video_strobe_i = 1'b0;
        wb_data_i = '0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
    endtask

    task automatic spi_req(input logic [15:0] a, input logic we);
        spi_cycle_i = 1'b1; spi_strobe_i = 1'b1; spi_addr_i = a; spi_we_i = we; spi_data_i = 8'h5C;
    endtask

    task automatic video_req(input logic [15:0] a, input logic we, input logic [7:0] d);
        video_cycle_i = 1'b1; video_strobe_i = 1'b1; video_addr_i = a; video_we_i = we; video_data_i = d;
    endtask

    task automatic drive(input int scn, input int c);
        idle_inputs();
        rst = 1'b0;
        wb_data_i = c[7:0];
        case (scn)
            2: begin
                if (c >= 5 && c <= 51) spi_req(16'h1234, 1'b0);
                if (c == 51) begin wb_ack_i = 1'b1; wb_data_i = 8'hA5; end
            end
            3: begin
                video_req(16'h0200, 1'b1, 8'h3C);
                spi_req(16'h1234, 1'b0);
                if ((c % FRAME) == 34 || (c % FRAME) == 50) wb_ack_i = 1'b1;
            end
            4: begin
                if (c >= 30) video_req(16'h0300, 1'b0, 8'h00);
                if (c >= 40) spi_req(16'h0042, 1'b1);
                if (c == 50) wb_ack_i = 1'b1;
            end
            5: begin
                if (c >= 32 && c <= 47) video_req(16'h0040, 1'b1, 8'h77);
                if (c == 10 || c == 20 || c == 47) wb_ack_i = 1'b1;
            end
            6: begin
                if (c >= 40 && c <= 52) spi_req(16'h0ABC, 1'b0);
                if (c == 50 || c == 51) rst = 1'b1;
                if (c == 52) wb_ack_i = 1'b1;
            end
            7: begin
                if (c < 100) video_req(16'h0111, 1'b0, 8'h00);
                if (c == 32) wb_stall_i = 1'b1;
                if (c == 101) wb_ack_i = 1'b1;
            end
            default: begin
            end
        endcase
    endtask

    task automatic literal(input int scn, input int c);
        case (scn)
            1: begin
                if (c == 0 || c == 16 || c == 32 || c == 48) chk("s1_grant_strobe_on", grant_strobe_o, 1);
                if (c == 1) chk("s1_grant_strobe_off", grant_strobe_o, 0);
                if (c == 0 || c == 31) chk("s1_cpu_grant_on", cpu_grant_o, 1);
                if (c == 32) chk("s1_cpu_grant_off", cpu_grant_o, 0);
            end
            2: begin
                if (c == 5 || c == 47) chk("s2_no_strobe", wb_strobe_o, 0);
                if (c == 48) begin
                    chk("s2_strobe48", wb_strobe_o, 1);
                    chk("s2_addr48", wb_addr_o, 32'h1234);
                    chk("s2_stall48", spi_stall_o, 0);
                end
                if (c == 51) begin
                    chk("s2_ack51", spi_ack_o, 1);
                    chk("s2_data51", spi_data_o, 32'hA5);
                end
            end
            3: begin
                if (wb_strobe_o) strobes_seen++;
                if (c == 32 || c == 48 || c == 160 || c == 176) chk("s3_strobe", wb_strobe_o, 1);
                if (c == 34) chk("s3_video_ack", video_ack_o, 1);
                if (c == 50) chk("s3_spi_ack", spi_ack_o, 1);
            end
            4: begin
                if (c == 46) chk("s4_err46", video_err_o, 0);
                if (c == 47) begin
                    chk("s4_err47", video_err_o, 1);
                    chk("s4_timeout47", timeout_o, 1);
                    chk("s4_vack47", video_ack_o, 0);
                end
                if (c == 48) begin
                    chk("s4_strobe48", wb_strobe_o, 1);
                    chk("s4_spi_stall48", spi_stall_o, 0);
                    chk("s4_video_stall48", video_stall_o, 1);
                end
                if (c == 50) chk("s4_spi_ack50", spi_ack_o, 1);
            end
            5: begin
                if (c == 10) begin
                    chk("s5_stray_vack", video_ack_o, 0);
                    chk("s5_stray_sack", spi_ack_o, 0);
                end
                if (c == 32) begin
                    chk("s5_wdata32", wb_data_o, 32'h77);
                    chk("s5_we32", wb_we_o, 1);
                end
                if (c == 47) begin
                    chk("s5_vack47", video_ack_o, 1);
                    chk("s5_verr47", video_err_o, 0);
                    chk("s5_timeout47", timeout_o, 0);
                end
            end
            6: begin
                if (c == 48) chk("s6_strobe48", wb_strobe_o, 1);
                if (c == 50) begin
                    chk("s6_rst_stall", spi_stall_o, 1);
                    chk("s6_rst_cpu", cpu_grant_o, 0);
                    chk("s6_rst_cycle", wb_cycle_o, 0);
                end
                if (c == 52) begin
                    chk("s6_late_ack", spi_ack_o, 0);
                    chk("s6_restart_gs", grant_strobe_o, 1);
                    chk("s6_restart_cpu", cpu_grant_o, 1);
                end
                if (c == 53) chk("s6_gs53", grant_strobe_o, 0);
            end
            7: begin
                if (c == 32) begin
                    chk("s7_stalled_strobe", wb_strobe_o, 0);
                    chk("s7_stalled_vstall", video_stall_o, 1);
                end
                if (c == 33) chk("s7_no_late_accept", wb_strobe_o, 0);
                if (c == 96) chk("s7_next_frame", wb_strobe_o, 1);
                if (c == 101) chk("s7_drop_no_ack", video_ack_o, 0);
            end
            default: begin
            end
        endcase
    endtask

    task automatic run(input int scn, input int ncyc);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            drive(scn, c);
            #1;
            literal(scn, c);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        chk("reset_spi_stall", spi_stall_o, 1);
        chk("reset_video_stall", video_stall_o, 1);
        chk("reset_cpu_grant", cpu_grant_o, 0);
        chk("reset_wb_strobe", wb_strobe_o, 0);
        chk("reset_wb_cycle", wb_cycle_o, 0);
        chk("reset_timeout", timeout_o, 0);
        run(1, 64);
        run(2, 64);
        strobes_seen = 0;
        run(3, 192);
        chk("s3_strobe_count", strobes_seen, 6);
        run(4, 64);
        run(5, 64);
        run(6, 80);
        run(7, 128);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
